itlb_array: RTL and testbench

- Parametrised, fully associative instruction-TLB storage for the MMS unit. Holds ENTRIES translations, each with valid bit, VPN/ASID tag, page level and PTE.
- Provides a one-cycle registered lookup, a refill write port with automatic victim selection, and RISC-V sfence.vma-style flush (all / by VPN / by ASID / both).
- Sits between IFU address generation and the page-table walker. Supersedes the single-entry PTE line register.

---
 rtl/itlb_array_pkg.sv | 28 ++
 rtl/itlb_array_if.sv | 49 ++++
 rtl/itlb_array_entry.sv | 102 ++++++++++
 rtl/itlb_array.sv | 156 +++++++++++++++
 tb/tb_itlb_array.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/itlb_array_pkg.sv
// Shared types and constants for the instruction-TLB array.
//   MXLEN       : PTE width (RV64)
//   PTE_G_BIT   : position of the global bit inside a PTE
//   pte_t       : raw page-table entry
//   itlb_level_e: page level of a translation (4K / 2M / 1G)
//   itlb_tag_t  : Sv39 translation tag {vpn, asid, level}
package itlb_array_pkg;

    localparam int unsigned MXLEN      = 64;
    localparam int unsigned PTE_G_BIT  = 5;
    localparam int unsigned SV39_VPN_W = 27;
    localparam int unsigned SV39_ASID_W = 16;

    typedef logic [MXLEN-1:0] pte_t;

    typedef enum logic [1:0] {
        LVL_4K = 2'd0,
        LVL_2M = 2'd1,
        LVL_1G = 2'd2
    } itlb_level_e;

    typedef struct packed {
        logic [SV39_VPN_W-1:0]  vpn;
        logic [SV39_ASID_W-1:0] asid;
        logic [1:0]             level;
    } itlb_tag_t;

endpackage

// File: rtl/itlb_array_if.sv
// Lookup / refill / flush bus of the instruction-TLB array.
//   master : IFU + page-table walker side (drives requests, receives responses)
//   slave  : the TLB array itself
// Signal names keep their _i/_o direction as seen from the TLB.
interface itlb_array_if
    import itlb_array_pkg::*;
#(
    parameter int unsigned VPN_W  = 27,
    parameter int unsigned ASID_W = 16
);
    // Lookup request and registered response
    logic              lookup_valid_i;
    logic [VPN_W-1:0]  lookup_vpn_i;
    logic [ASID_W-1:0] lookup_asid_i;
    logic              resp_valid_o;
    logic              resp_hit_o;
    pte_t              resp_pte_o;
    logic [1:0]        resp_level_o;
    // Refill write port
    logic              refill_valid_i;
    logic              refill_ready_o;
    logic [VPN_W-1:0]  refill_vpn_i;
    logic [ASID_W-1:0] refill_asid_i;
    logic [1:0]        refill_level_i;
    pte_t              refill_pte_i;
    // sfence.vma-style flush
    logic              flush_i;
    logic              flush_vpn_valid_i;
    logic              flush_asid_valid_i;
    logic [VPN_W-1:0]  flush_vpn_i;
    logic [ASID_W-1:0] flush_asid_i;

    modport master (
        output lookup_valid_i, lookup_vpn_i, lookup_asid_i,
        input  resp_valid_o, resp_hit_o, resp_pte_o, resp_level_o,
        output refill_valid_i, refill_vpn_i, refill_asid_i, refill_level_i, refill_pte_i,
        input  refill_ready_o,
        output flush_i, flush_vpn_valid_i, flush_asid_valid_i, flush_vpn_i, flush_asid_i
    );

    modport slave (
        input  lookup_valid_i, lookup_vpn_i, lookup_asid_i,
        output resp_valid_o, resp_hit_o, resp_pte_o, resp_level_o,
        input  refill_valid_i, refill_vpn_i, refill_asid_i, refill_level_i, refill_pte_i,
        output refill_ready_o,
        input  flush_i, flush_vpn_valid_i, flush_asid_valid_i, flush_vpn_i, flush_asid_i
    );

endinterface

// File: rtl/itlb_array_entry.sv
// One fully-associative TLB entry: valid bit, {vpn, asid, level} tag and PTE.
//   clk_i, rstn_i      : clock, synchronous active-low reset (valid bit only)
//   i_write / i_wr_*   : load a new translation, sets valid
//   i_inval            : clear valid (wins over i_write)
//   i_lk_*             : lookup key      -> o_lookup_hit
//   i_fl_*             : flush qualifiers -> o_flush_hit (entry selected by flush)
//   i_wr_* tag         : refill key      -> o_tag_hit (exact tag already resident)
//   o_valid, o_level, o_pte : stored state for the array's muxes
module itlb_array_entry
    import itlb_array_pkg::*;
#(
    parameter int unsigned VPN_W  = 27,
    parameter int unsigned ASID_W = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              i_write,
    input  logic              i_inval,
    input  logic [VPN_W-1:0]  i_wr_vpn,
    input  logic [ASID_W-1:0] i_wr_asid,
    input  logic [1:0]        i_wr_level,
    input  pte_t              i_wr_pte,
    input  logic [VPN_W-1:0]  i_lk_vpn,
    input  logic [ASID_W-1:0] i_lk_asid,
    input  logic              i_fl_vpn_valid,
    input  logic              i_fl_asid_valid,
    input  logic [VPN_W-1:0]  i_fl_vpn,
    input  logic [ASID_W-1:0] i_fl_asid,
    output logic              o_valid,
    output logic              o_lookup_hit,
    output logic              o_flush_hit,
    output logic              o_tag_hit,
    output logic [1:0]        o_level,
    output pte_t              o_pte
);

    logic              r_valid;
    logic [VPN_W-1:0]  r_vpn;
    logic [ASID_W-1:0] r_asid;
    logic [1:0]        r_level;
    pte_t              r_pte;

    logic w_global;
    logic w_lk_vpn_hit;
    logic w_fl_vpn_hit;
    logic w_fl_asid_hit;

    // Superpages ignore the low 9 (2M) or 18 (1G) VPN bits; level 3 never matches.
    function automatic logic vpn_match(input logic [VPN_W-1:0] a, input logic [VPN_W-1:0] b,
                                       input logic [1:0] lvl);
        logic hi, mid, lo, res;
        hi  = (a[VPN_W-1:18] == b[VPN_W-1:18]);
        mid = (a[17:9] == b[17:9]);
        lo  = (a[8:0] == b[8:0]);
        case (lvl)
            LVL_4K:  res = hi & mid & lo;
            LVL_2M:  res = hi & mid;
            LVL_1G:  res = hi;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_valid <= 1'b0;
        end else if (i_inval) begin
            r_valid <= 1'b0;
        end else if (i_write) begin
            r_valid <= 1'b1;
        end
    end

    // Payload is deliberately not reset; valid gates every use of it.
    always_ff @(posedge clk_i) begin
        if (i_write) begin
            r_vpn   <= i_wr_vpn;
            r_asid  <= i_wr_asid;
            r_level <= i_wr_level;
            r_pte   <= i_wr_pte;
        end
    end

    always_comb begin
        w_global      = r_pte[PTE_G_BIT];
        w_lk_vpn_hit  = vpn_match(r_vpn, i_lk_vpn, r_level);
        w_fl_vpn_hit  = vpn_match(r_vpn, i_fl_vpn, r_level);
        w_fl_asid_hit = !w_global && (r_asid == i_fl_asid);

        o_lookup_hit = r_valid && w_lk_vpn_hit && (w_global || (r_asid == i_lk_asid));
        // Each qualifier narrows the flush; global entries escape any ASID-qualified flush.
        o_flush_hit  = r_valid
                       && (!i_fl_vpn_valid || w_fl_vpn_hit)
                       && (!i_fl_asid_valid || w_fl_asid_hit);
        o_tag_hit    = r_valid && (r_vpn == i_wr_vpn) && (r_asid == i_wr_asid)
                       && (r_level == i_wr_level);
        o_valid      = r_valid;
        o_level      = r_level;
        o_pte        = r_pte;
    end

endmodule

// File: rtl/itlb_array.sv
// Fully-associative instruction-TLB storage.
//   clk_i  : clock
//   rstn_i : synchronous active-low reset
//   bus    : itlb_array_if.slave -- lookup (1-cycle registered response),
//            refill with automatic victim selection, sfence.vma-style flush
// Holds the lookup/victim priority encoders, the round-robin pointer and the
// response registers; per-entry matching lives in itlb_array_entry.
module itlb_array
    import itlb_array_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned VPN_W   = 27,
    parameter int unsigned ASID_W  = 16,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    itlb_array_if.slave  bus
);

    logic [ENTRIES-1:0] w_valid;
    logic [ENTRIES-1:0] w_lk_hit;
    logic [ENTRIES-1:0] w_fl_hit;
    logic [ENTRIES-1:0] w_tag_hit;
    logic [ENTRIES-1:0] w_wr_en;
    logic [ENTRIES-1:0] w_inval;
    logic [1:0]         w_level [ENTRIES];
    pte_t               w_pte   [ENTRIES];

    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_rr_ptr_d;
    logic [IDX_W-1:0] w_tag_idx;
    logic [IDX_W-1:0] w_free_idx;
    logic [IDX_W-1:0] w_victim;
    logic             w_use_rr;
    logic             w_refill_fire;

    logic             w_lk_any;
    pte_t             w_lk_pte;
    logic [1:0]       w_lk_level;

    logic             r_resp_valid;
    logic             r_resp_hit;
    pte_t             r_resp_pte;
    logic [1:0]       r_resp_level;
    logic             w_resp_hit_d;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        itlb_array_entry #(
            .VPN_W  (VPN_W),
            .ASID_W (ASID_W)
        ) u_entry (
            .clk_i           (clk_i),
            .rstn_i          (rstn_i),
            .i_write         (w_wr_en[g]),
            .i_inval         (w_inval[g]),
            .i_wr_vpn        (bus.refill_vpn_i),
            .i_wr_asid       (bus.refill_asid_i),
            .i_wr_level      (bus.refill_level_i),
            .i_wr_pte        (bus.refill_pte_i),
            .i_lk_vpn        (bus.lookup_vpn_i),
            .i_lk_asid       (bus.lookup_asid_i),
            .i_fl_vpn_valid  (bus.flush_vpn_valid_i),
            .i_fl_asid_valid (bus.flush_asid_valid_i),
            .i_fl_vpn        (bus.flush_vpn_i),
            .i_fl_asid       (bus.flush_asid_i),
            .o_valid         (w_valid[g]),
            .o_lookup_hit    (w_lk_hit[g]),
            .o_flush_hit     (w_fl_hit[g]),
            .o_tag_hit       (w_tag_hit[g]),
            .o_level         (w_level[g]),
            .o_pte           (w_pte[g])
        );

        assign w_wr_en[g] = w_refill_fire && (w_victim == IDX_W'(g));
        assign w_inval[g] = bus.flush_i && w_fl_hit[g];
    end

    // Flush owns the cycle; a refill offered alongside it is simply not accepted.
    assign bus.refill_ready_o = !bus.flush_i;
    assign w_refill_fire      = bus.refill_valid_i && !bus.flush_i;

    // Lowest-index lookup hit; downward scan so the last assignment is the lowest index.
    always_comb begin
        w_lk_any   = |w_lk_hit;
        w_lk_pte   = '0;
        w_lk_level = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (w_lk_hit[i]) begin
                w_lk_pte   = w_pte[i];
                w_lk_level = w_level[i];
            end
        end
    end

    // Victim: resident identical tag, else lowest free slot, else round-robin.
    always_comb begin
        w_tag_idx  = '0;
        w_free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (w_tag_hit[i]) begin
                w_tag_idx = IDX_W'(i);
            end
            if (!w_valid[i]) begin
                w_free_idx = IDX_W'(i);
            end
        end

        w_use_rr = 1'b0;
        if (|w_tag_hit) begin
            w_victim = w_tag_idx;
        end else if (!(&w_valid)) begin
            w_victim = w_free_idx;
        end else begin
            w_victim = r_rr_ptr;
            w_use_rr = 1'b1;
        end

        // ENTRIES is a power of two, so the natural IDX_W wrap is the modulo.
        w_rr_ptr_d = r_rr_ptr;
        if (w_refill_fire && w_use_rr) begin
            w_rr_ptr_d = r_rr_ptr + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_rr_ptr <= '0;
        end else begin
            r_rr_ptr <= w_rr_ptr_d;
        end
    end

    // A lookup that coincides with a flush is forced to miss.
    assign w_resp_hit_d = bus.lookup_valid_i && !bus.flush_i && w_lk_any;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_pte   <= '0;
            r_resp_level <= '0;
        end else begin
            r_resp_valid <= bus.lookup_valid_i;
            r_resp_hit   <= w_resp_hit_d;
            r_resp_pte   <= w_resp_hit_d ? w_lk_pte : '0;
            r_resp_level <= w_resp_hit_d ? w_lk_level : 2'd0;
        end
    end

    assign bus.resp_valid_o = r_resp_valid;
    assign bus.resp_hit_o   = r_resp_hit;
    assign bus.resp_pte_o   = r_resp_pte;
    assign bus.resp_level_o = r_resp_level;

endmodule

// File: tb/tb_itlb_array.sv
// Self-checking bench for itlb_array: directed scenarios followed by random
// traffic, all checked against a table-based reference model of the TLB.
module tb_itlb_array;
    import itlb_array_pkg::*;

    localparam int N = 16;

    logic clk_i;
    logic rstn_i;

    itlb_array_if #(.VPN_W(27), .ASID_W(16)) bus ();

    itlb_array #(
        .ENTRIES (N),
        .VPN_W   (27),
        .ASID_W  (16)
    ) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a table of slots plus the replacement pointer.
    bit         m_valid [N];
    itlb_tag_t  m_tag   [N];
    logic [63:0] m_pte  [N];
    int         m_ptr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A page of size 4K * 512^lvl covers every VPN sharing vpn / 512^lvl.
    function automatic bit m_vpn_match(input logic [26:0] e, input logic [26:0] q,
                                       input logic [1:0] lvl);
        int unsigned span;
        if (lvl == 2'd3) return 1'b0;
        span = 1 << (9 * int'(lvl));
        return (int'(e) / span) == (int'(q) / span);
    endfunction

    task automatic m_lookup(input logic [26:0] vpn, input logic [15:0] asid,
                            output bit hit, output logic [63:0] pte, output logic [1:0] lvl);
        hit = 1'b0; pte = '0; lvl = '0;
        for (int i = 0; i < N; i++) begin
            if (!hit && m_valid[i] && m_vpn_match(m_tag[i].vpn, vpn, m_tag[i].level)
                && (m_pte[i][5] || m_tag[i].asid == asid)) begin
                hit = 1'b1; pte = m_pte[i]; lvl = m_tag[i].level;
            end
        end
    endtask

    task automatic m_refill(input itlb_tag_t t, input logic [63:0] pte);
        int slot = -1;
        for (int i = 0; i < N; i++)
            if (slot < 0 && m_valid[i] && m_tag[i] == t) slot = i;
        if (slot < 0)
            for (int i = 0; i < N; i++)
                if (slot < 0 && !m_valid[i]) slot = i;
        if (slot < 0) begin
            slot  = m_ptr;
            m_ptr = (m_ptr + 1) % N;
        end
        m_valid[slot] = 1'b1; m_tag[slot] = t; m_pte[slot] = pte;
    endtask

    task automatic m_flush(input bit vv, input bit av, input logic [26:0] vpn,
                           input logic [15:0] asid);
        for (int i = 0; i < N; i++) begin
            bit sel = m_valid[i];
            if (vv && !m_vpn_match(m_tag[i].vpn, vpn, m_tag[i].level)) sel = 1'b0;
            if (av && (m_pte[i][5] || m_tag[i].asid != asid)) sel = 1'b0;
            if (sel) m_valid[i] = 1'b0;
        end
    endtask

    // Captured response of the most recent step, for directed expectations.
    logic        last_hit;
    logic [63:0] last_pte;
    logic [1:0]  last_lvl;

    // One clock: drive inputs, check ready, clock, update model, check response.
    task automatic step(input bit lk, input logic [26:0] lvpn, input logic [15:0] lasid,
                        input bit rf, input logic [26:0] rvpn, input logic [15:0] rasid,
                        input logic [1:0] rlvl, input logic [63:0] rpte,
                        input bit fl, input bit fvv, input bit fav,
                        input logic [26:0] fvpn, input logic [15:0] fasid);
        bit          h;
        logic [63:0] p;
        logic [1:0]  l;
        itlb_tag_t   t;
        bus.lookup_valid_i = lk;  bus.lookup_vpn_i = lvpn;  bus.lookup_asid_i = lasid;
        bus.refill_valid_i = rf;  bus.refill_vpn_i = rvpn;  bus.refill_asid_i = rasid;
        bus.refill_level_i = rlvl; bus.refill_pte_i = rpte;
        bus.flush_i = fl; bus.flush_vpn_valid_i = fvv; bus.flush_asid_valid_i = fav;
        bus.flush_vpn_i = fvpn; bus.flush_asid_i = fasid;
        #1;
        chk("refill_ready", 64'(bus.refill_ready_o), 64'(!fl));
        m_lookup(lvpn, lasid, h, p, l);
        h = h && lk && !fl;
        if (!h) begin p = '0; l = '0; end
        @(posedge clk_i);
        t.vpn = rvpn; t.asid = rasid; t.level = rlvl;
        if (fl)      m_flush(fvv, fav, fvpn, fasid);
        else if (rf) m_refill(t, rpte);
        #1;
        chk("resp_valid", 64'(bus.resp_valid_o), 64'(lk));
        chk("resp_hit",   64'(bus.resp_hit_o),   64'(h));
        chk("resp_pte",   bus.resp_pte_o,        p);
        chk("resp_level", 64'(bus.resp_level_o), 64'(l));
        last_hit = bus.resp_hit_o; last_pte = bus.resp_pte_o; last_lvl = bus.resp_level_o;
    endtask

    task automatic lookup(input logic [26:0] vpn, input logic [15:0] asid);
        step(1, vpn, asid, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic refill(input logic [26:0] vpn, input logic [15:0] asid,
                          input logic [1:0] lvl, input logic [63:0] pte);
        step(0, 0, 0, 1, vpn, asid, lvl, pte, 0, 0, 0, 0, 0);
    endtask

    task automatic flush(input bit vv, input bit av, input logic [26:0] vpn,
                         input logic [15:0] asid);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, vv, av, vpn, asid);
    endtask

    // Reset with a lookup in flight: its response must be dropped.
    task automatic do_reset();
        rstn_i = 1'b0;
        bus.lookup_valid_i = 1'b1; bus.lookup_vpn_i = 27'h1234; bus.lookup_asid_i = 16'd1;
        bus.refill_valid_i = 1'b0; bus.flush_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        bus.lookup_valid_i = 1'b0;
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        m_ptr = 0;
        chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
        chk("rst_resp_hit",   64'(bus.resp_hit_o),   64'd0);
        chk("rst_resp_pte",   bus.resp_pte_o,        64'd0);
        chk("rst_resp_level", 64'(bus.resp_level_o), 64'd0);
    endtask

    initial begin
        logic [63:0] gpte;
        rstn_i = 1'b0;
        bus.lookup_valid_i = 0; bus.lookup_vpn_i = 0; bus.lookup_asid_i = 0;
        bus.refill_valid_i = 0; bus.refill_vpn_i = 0; bus.refill_asid_i = 0;
        bus.refill_level_i = 0; bus.refill_pte_i = 0;
        bus.flush_i = 0; bus.flush_vpn_valid_i = 0; bus.flush_asid_valid_i = 0;
        bus.flush_vpn_i = 0; bus.flush_asid_i = 0;
        m_ptr = 0;

        // Empty TLB misses
        do_reset();
        lookup(27'h1234, 16'd1);
        chk("empty_valid", 64'(bus.resp_valid_o), 64'd1);
        chk("empty_hit", 64'(last_hit), 64'd0);

        // Basic 4K refill and ASID separation
        refill(27'h1234, 16'd1, 2'd0, 64'hCF);
        lookup(27'h1234, 16'd1);
        chk("4k_hit", 64'(last_hit), 64'd1);
        chk("4k_pte", last_pte, 64'hCF);
        lookup(27'h1234, 16'd2);
        chk("4k_other_asid", 64'(last_hit), 64'd0);

        // Global 1G page survives ASID flush, dies on full flush
        gpte = 64'h2F;
        refill(27'h40000, 16'd3, 2'd2, gpte);
        lookup(27'h4ABCD, 16'd7);
        chk("1g_hit", 64'(last_hit), 64'd1);
        chk("1g_level", 64'(last_lvl), 64'd2);
        flush(0, 1, 0, 16'd7);
        lookup(27'h4ABCD, 16'd7);
        chk("1g_after_asid_flush", 64'(last_hit), 64'd1);
        flush(0, 0, 0, 0);
        lookup(27'h4ABCD, 16'd7);
        chk("1g_after_full_flush", 64'(last_hit), 64'd0);

        // Round-robin replacement on a full TLB
        do_reset();
        for (int i = 0; i < N; i++) refill(27'h100 + 27'(i), 16'd1, 2'd0, 64'h1000 + 64'(i));
        for (int j = 0; j < 3; j++) refill(27'h200 + 27'(j), 16'd1, 2'd0, 64'h2000 + 64'(j));
        lookup(27'h100, 16'd1);
        chk("rr_evict0", 64'(last_hit), 64'd0);
        lookup(27'h102, 16'd1);
        chk("rr_evict2", 64'(last_hit), 64'd0);
        lookup(27'h103, 16'd1);
        chk("rr_keep3", 64'(last_hit), 64'd1);
        lookup(27'h202, 16'd1);
        chk("rr_new2", last_pte, 64'h2002);
        refill(27'h105, 16'd1, 2'd0, 64'h5555);
        lookup(27'h105, 16'd1);
        chk("inplace_pte", last_pte, 64'h5555);
        refill(27'h300, 16'd1, 2'd0, 64'h3000);
        lookup(27'h103, 16'd1);
        chk("ptr_was_3", 64'(last_hit), 64'd0);
        lookup(27'h104, 16'd1);
        chk("ptr_keep4", 64'(last_hit), 64'd1);

        // Flush + refill + lookup in one cycle
        step(1, 27'h104, 16'd1, 1, 27'h400, 16'd1, 2'd0, 64'h4000, 1, 0, 0, 0, 0);
        chk("same_cycle_miss", 64'(last_hit), 64'd0);
        lookup(27'h104, 16'd1);
        chk("same_cycle_next", 64'(last_hit), 64'd0);
        lookup(27'h400, 16'd1);
        chk("same_cycle_dropped", 64'(last_hit), 64'd0);

        // VPN-only flush across ASIDs
        refill(27'h1234, 16'd1, 2'd0, 64'h0F);
        refill(27'h1234, 16'd2, 2'd0, 64'h1F);
        refill(27'h5678, 16'd1, 2'd0, 64'h0F);
        flush(1, 0, 27'h1234, 0);
        lookup(27'h1234, 16'd1);
        chk("vflush_a1", 64'(last_hit), 64'd0);
        lookup(27'h1234, 16'd2);
        chk("vflush_a2", 64'(last_hit), 64'd0);
        lookup(27'h5678, 16'd1);
        chk("vflush_other", 64'(last_hit), 64'd1);

        // Random traffic against the model
        for (int k = 0; k < 1500; k++) begin
            logic [26:0] v1, v2, v3;
            logic [63:0] p;
            v1 = 27'(($urandom_range(0, 3) << 18) | ($urandom_range(0, 3) << 9)
                     | $urandom_range(0, 3));
            v2 = 27'(($urandom_range(0, 3) << 18) | ($urandom_range(0, 3) << 9)
                     | $urandom_range(0, 3));
            v3 = 27'(($urandom_range(0, 3) << 18) | ($urandom_range(0, 3) << 9)
                     | $urandom_range(0, 3));
            p = {$urandom, $urandom};
            p[5] = ($urandom_range(0, 3) == 0);
            step($urandom_range(0, 9) < 7, v1, 16'($urandom_range(0, 2)),
                 $urandom_range(0, 1) == 1, v2, 16'($urandom_range(0, 2)),
                 2'($urandom_range(0, 2)), p,
                 $urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, v3, 16'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
